// File: rtl/dallanma_ongorucu.sv
// Fetch-side branch predictor: direct-mapped BTB plus bimodal 2-bit counter table.
// Latency: one cycle from a valid fetch PC to a registered taken/target prediction.
// Backpressure: g1_durdur_i holds the prediction outputs; a G2 mispredict update forces them to zero.
module dallanma_ongorucu #(
  parameter int         BTB_SATIR   = 32,
  parameter int         PHT_SATIR   = 64,
  parameter logic [1:0] SAYAC_SIFIR = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] g1_ps_i,
  input  logic        g1_ps_gecerli_i,
  input  logic        g1_durdur_i,
  output logic        g1_tahmin_gecerli_o,
  output logic        g1_tahmin_atladi_o,
  output logic [31:0] g1_tahmin_ps_o,
  input  logic [31:0] g2_ps_i,
  input  logic [31:0] g2_hedef_ps_i,
  input  logic        g2_guncelle_i,
  input  logic        g2_atladi_i,
  input  logic        g2_hatali_tahmin_i
);

  // PCs are halfword aligned, so bit 0 never takes part in indexing or tagging.
  localparam int BI = $clog2(BTB_SATIR);
  localparam int PI = $clog2(PHT_SATIR);
  localparam int TW = 31 - BI;

  logic          btb_gecerli [BTB_SATIR];
  logic [TW-1:0] btb_etiket  [BTB_SATIR];
  logic [31:0]   btb_hedef   [BTB_SATIR];
  logic [1:0]    sayac       [PHT_SATIR];

  logic [BI-1:0] g1_btb_idx;
  logic [TW-1:0] g1_etiket;
  logic [PI-1:0] g1_pht_idx;
  logic [BI-1:0] g2_btb_idx;
  logic [TW-1:0] g2_etiket;
  logic [PI-1:0] g2_pht_idx;

  logic          bak_isabet;
  logic          bak_atladi;
  logic [31:0]   bak_hedef;
  logic [1:0]    sayac_eski;
  logic [1:0]    sayac_yeni;
  logic          unused_lsb;

  assign g1_btb_idx = g1_ps_i[BI:1];
  assign g1_etiket  = g1_ps_i[31:BI+1];
  assign g1_pht_idx = g1_ps_i[PI:1];
  assign g2_btb_idx = g2_ps_i[BI:1];
  assign g2_etiket  = g2_ps_i[31:BI+1];
  assign g2_pht_idx = g2_ps_i[PI:1];
  assign unused_lsb = g1_ps_i[0] ^ g2_ps_i[0];

  // Lookup reads the tables as they stand before this edge's update (read-before-write).
  always_comb begin
    bak_isabet = 1'b0;
    bak_atladi = 1'b0;
    bak_hedef  = 32'd0;
    bak_isabet = btb_gecerli[g1_btb_idx] && (btb_etiket[g1_btb_idx] == g1_etiket);
    bak_atladi = bak_isabet && sayac[g1_pht_idx][1];
    if (bak_atladi) begin
      bak_hedef = btb_hedef[g1_btb_idx];
    end
  end

  // Saturating counter step for the resolved branch.
  always_comb begin
    sayac_eski = sayac[g2_pht_idx];
    sayac_yeni = sayac_eski;
    if (g2_atladi_i) begin
      if (sayac_eski != 2'b11) begin
        sayac_yeni = sayac_eski + 2'd1;
      end
    end else begin
      if (sayac_eski != 2'b00) begin
        sayac_yeni = sayac_eski - 2'd1;
      end
    end
  end

  // Counter table: reset to weakly not-taken, one update per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PHT_SATIR; i++) begin
        sayac[i] <= SAYAC_SIFIR;
      end
    end else if (g2_guncelle_i) begin
      sayac[g2_pht_idx] <= sayac_yeni;
    end
  end

  // BTB valid bits: cleared by reset, set by a taken resolution.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_SATIR; i++) begin
        btb_gecerli[i] <= 1'b0;
      end
    end else if (g2_guncelle_i && g2_atladi_i) begin
      btb_gecerli[g2_btb_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload; an aliasing taken branch simply replaces the entry.
  always_ff @(posedge clk_i) begin
    if (!rst_i && g2_guncelle_i && g2_atladi_i) begin
      btb_etiket[g2_btb_idx] <= g2_etiket;
      btb_hedef[g2_btb_idx]  <= g2_hedef_ps_i;
    end
  end

  // Prediction register: mispredict flush beats stall, stall beats a new lookup.
  always_ff @(posedge clk_i) begin
    if (rst_i || (g2_guncelle_i && g2_hatali_tahmin_i)) begin
      g1_tahmin_gecerli_o <= 1'b0;
      g1_tahmin_atladi_o  <= 1'b0;
      g1_tahmin_ps_o      <= 32'd0;
    end else if (!g1_durdur_i) begin
      if (g1_ps_gecerli_i) begin
        g1_tahmin_gecerli_o <= bak_isabet;
        g1_tahmin_atladi_o  <= bak_atladi;
        g1_tahmin_ps_o      <= bak_hedef;
      end else begin
        g1_tahmin_gecerli_o <= 1'b0;
        g1_tahmin_atladi_o  <= 1'b0;
        g1_tahmin_ps_o      <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Bench for dallanma_ongorucu: table-driven cycles with a scoreboard of expected predictions.
// Each row is checked one cycle after it is driven.
// Stalls and mispredict flushes are exercised explicitly.
module tb_dallanma_ongorucu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] g1_ps_i = 32'd0;
  logic        g1_ps_gecerli_i = 1'b0;
  logic        g1_durdur_i = 1'b0;
  logic        g1_tahmin_gecerli_o;
  logic        g1_tahmin_atladi_o;
  logic [31:0] g1_tahmin_ps_o;
  logic [31:0] g2_ps_i = 32'd0;
  logic [31:0] g2_hedef_ps_i = 32'd0;
  logic        g2_guncelle_i = 1'b0;
  logic        g2_atladi_i = 1'b0;
  logic        g2_hatali_tahmin_i = 1'b0;

  int total = 0;
  int bad = 0;
  logic [33:0] sb[$];
  logic [33:0] obs;
  logic [33:0] e;

  assign obs = {g1_tahmin_gecerli_o, g1_tahmin_atladi_o, g1_tahmin_ps_o};

  typedef struct {
    logic        rst;
    logic [31:0] ps;
    logic        vld;
    logic        dur;
    logic [31:0] g2ps;
    logic [31:0] g2h;
    logic        gun;
    logic        atl;
    logic        hat;
    logic [33:0] exp;
  } row_t;

  localparam logic [33:0] Z = 34'd0;

  dallanma_ongorucu dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .g1_ps_i            (g1_ps_i),
    .g1_ps_gecerli_i    (g1_ps_gecerli_i),
    .g1_durdur_i        (g1_durdur_i),
    .g1_tahmin_gecerli_o(g1_tahmin_gecerli_o),
    .g1_tahmin_atladi_o (g1_tahmin_atladi_o),
    .g1_tahmin_ps_o     (g1_tahmin_ps_o),
    .g2_ps_i            (g2_ps_i),
    .g2_hedef_ps_i      (g2_hedef_ps_i),
    .g2_guncelle_i      (g2_guncelle_i),
    .g2_atladi_i        (g2_atladi_i),
    .g2_hatali_tahmin_i (g2_hatali_tahmin_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic row_t mk(logic rst, logic [31:0] ps, logic vld, logic dur,
                              logic [31:0] g2ps, logic [31:0] g2h, logic gun,
                              logic atl, logic hat, logic [33:0] exp);
    row_t r;
    r.rst = rst; r.ps = ps; r.vld = vld; r.dur = dur;
    r.g2ps = g2ps; r.g2h = g2h; r.gun = gun; r.atl = atl; r.hat = hat;
    r.exp = exp;
    return r;
  endfunction

  // Lookup only.
  function automatic row_t lk(logic [31:0] ps, logic [33:0] exp);
    return mk(1'b0, ps, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  // Update only, no lookup, no stall: outputs go to zero.
  function automatic row_t up(logic [31:0] g2ps, logic [31:0] g2h, logic atl);
    return mk(1'b0, 32'd0, 1'b0, 1'b0, g2ps, g2h, 1'b1, atl, 1'b0, Z);
  endfunction

  function automatic logic [33:0] pr(logic v, logic a, logic [31:0] ps);
    return {v, a, ps};
  endfunction

  task automatic apply(input row_t r);
    rst_i              = r.rst;
    g1_ps_i            = r.ps;
    g1_ps_gecerli_i    = r.vld;
    g1_durdur_i        = r.dur;
    g2_ps_i            = r.g2ps;
    g2_hedef_ps_i      = r.g2h;
    g2_guncelle_i      = r.gun;
    g2_atladi_i        = r.atl;
    g2_hatali_tahmin_i = r.hat;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mk(1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, Z));
    rows.push_back(lk(32'h0040_0000, Z));
    rows.push_back(lk(32'h0040_0004, Z));
    rows.push_back(lk(32'h0040_0010, Z));
    rows.push_back(lk(32'h0040_0050, Z));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_taken_train();
    row_t rows[$];
    rows.push_back(up(32'h0040_0010, 32'h0040_0040, 1'b1));
    rows.push_back(up(32'h0040_0010, 32'h0040_0040, 1'b1));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b1, 32'h0040_0040)));
    rows.push_back(up(32'h0040_0010, 32'h0040_0040, 1'b1));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b1, 32'h0040_0040)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL taken_train[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_not_taken();
    row_t rows[$];
    rows.push_back(up(32'h0040_0010, 32'h0, 1'b0));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b1, 32'h0040_0040)));
    rows.push_back(up(32'h0040_0010, 32'h0, 1'b0));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b0, 32'h0)));
    rows.push_back(up(32'h0040_0010, 32'h0, 1'b0));
    rows.push_back(up(32'h0040_0010, 32'h0, 1'b0));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b0, 32'h0)));
    rows.push_back(up(32'h0040_0010, 32'h0040_0040, 1'b1));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b0, 32'h0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL not_taken[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_alias();
    row_t rows[$];
    rows.push_back(up(32'h0040_0050, 32'h0040_0090, 1'b1));
    rows.push_back(lk(32'h0040_0010, Z));
    rows.push_back(lk(32'h0040_0050, pr(1'b1, 1'b1, 32'h0040_0090)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL alias[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    logic [33:0] hit10;
    hit10 = pr(1'b1, 1'b1, 32'h0040_0040);
    rows.push_back(up(32'h0040_0010, 32'h0040_0040, 1'b1));
    rows.push_back(lk(32'h0040_0010, hit10));
    rows.push_back(mk(1'b0, 32'h0040_0100, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, hit10));
    rows.push_back(mk(1'b0, 32'h0040_0100, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, hit10));
    rows.push_back(mk(1'b0, 32'h0040_0100, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, hit10));
    rows.push_back(mk(1'b0, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0020, 32'd0, 1'b1, 1'b0, 1'b1, Z));
    rows.push_back(mk(1'b0, 32'h0040_0010, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, Z));
    rows.push_back(lk(32'h0040_0010, hit10));
    rows.push_back(mk(1'b0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0020, 32'd0, 1'b1, 1'b0, 1'b1, Z));
    rows.push_back(lk(32'h0040_0010, hit10));
    rows.push_back(mk(1'b0, 32'h0040_0010, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, Z));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL stall[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_same_cycle();
    row_t rows[$];
    rows.push_back(mk(1'b0, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0200, 32'h0040_0280, 1'b1, 1'b1, 1'b0, Z));
    rows.push_back(lk(32'h0040_0200, pr(1'b1, 1'b1, 32'h0040_0280)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL same_cycle[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b1, 32'h0040_0040)));
    rows.push_back(lk(32'h0040_0050, Z));
    rows.push_back(lk(32'h0040_0200, pr(1'b1, 1'b1, 32'h0040_0280)));
    rows.push_back(mk(1'b0, 32'h0040_0200, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, Z));
    rows.push_back(lk(32'h0040_0000, Z));
    rows.push_back(lk(32'h0040_0010, pr(1'b1, 1'b1, 32'h0040_0040)));
    rows.push_back(mk(1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0200, 32'h0040_0300, 1'b1, 1'b1, 1'b0, Z));
    rows.push_back(lk(32'h0040_0010, Z));
    rows.push_back(lk(32'h0040_0200, Z));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_taken_train();
    test_not_taken();
    test_alias();
    test_stall();
    test_same_cycle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
